// File: rtl/pbl_pkg.sv
// Shared definitions for the push-button conditioning blocks: debouncer state
// encoding and the clock/debounce timing the default qualification time derives from.
package pbl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } deb_state_t;

    localparam int CLK_FREQ_HZ = 50000000;
    localparam int DEBOUNCE_MS = 20;
    localparam int DEFAULT_STABLE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit input; the reset value
// lets each user park the chain at its input's idle level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronise, normalise to 1 = pressed, then accept a new
// level only after it holds for STABLE_CYCLES clocks; emits one-cycle press/release pulses.
module button_debouncer
    import pbl_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 btn_sync;
    logic                 s;
    deb_state_t           state;
    deb_state_t           state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 level_next;
    logic                 pulse_next;
    logic                 release_next;

    // Chain parks at the raw not-pressed level so reset release never looks like a press.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    assign s = btn_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            btn_level   <= level_next;
            btn_pulse   <= pulse_next;
            btn_release <= release_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
        endcase
    end

    // Outputs are decoded from the upcoming state and registered alongside it.
    always_comb begin
        level_next   = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
        pulse_next   = (state == WAIT_PRESS) && (state_next == PRESSED);
        release_next = (state == WAIT_RELEASE) && (state_next == IDLE);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an abstract stable-run model checked every cycle,
// plus directed scenarios with hand-computed latencies and pulse counts.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic level_a, pulse_a, rel_a;
    logic level_b, pulse_b, rel_b;

    int total = 0;
    int bad = 0;
    int pcnt_a = 0, rcnt_a = 0, pcnt_b = 0, rcnt_b = 0;

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .btn_in(btn_a),
        .btn_level(level_a), .btn_pulse(pulse_a), .btn_release(rel_a)
    );

    button_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .btn_in(btn_b),
        .btn_level(level_b), .btn_pulse(pulse_b), .btn_release(rel_b)
    );

    // Model: the pressed level seen by the filter lags the pin by two edges; the
    // accepted level flips once that lagged value has differed for STABLE+1 edges.
    typedef struct {
        bit d0;
        bit d1;
        int run;
        bit level;
        bit pulse;
        bit rel;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, bit pressed_now, int stable);
        mdl_t r;
        bit seen;
        r = m;
        seen = m.d1;
        r.d1 = m.d0;
        r.d0 = pressed_now;
        r.pulse = 1'b0;
        r.rel = 1'b0;
        r.run = (seen != m.level) ? m.run + 1 : 0;
        if (r.run == stable + 1) begin
            r.level = seen;
            r.pulse = seen;
            r.rel = !seen;
            r.run = 0;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) ma <= '{default: 0};
        else       ma <= mstep(ma, !btn_a, 4);
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) mb <= '{default: 0};
        else       mb <= mstep(mb, btn_b, 1);
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        check("level_a", int'(level_a), int'(ma.level));
        check("pulse_a", int'(pulse_a), int'(ma.pulse));
        check("release_a", int'(rel_a), int'(ma.rel));
        check("level_b", int'(level_b), int'(mb.level));
        check("pulse_b", int'(pulse_b), int'(mb.pulse));
        check("release_b", int'(rel_b), int'(mb.rel));
        check("excl_a", int'(pulse_a & rel_a), 0);
        check("excl_b", int'(pulse_b & rel_b), 0);
        check("cnt_bound_a", int'(int'(dut_a.cnt) <= 3), 1);
        check("cnt_bound_b", int'(int'(dut_b.cnt) <= 0), 1);
        if (pulse_a) pcnt_a++;
        if (rel_a)   rcnt_a++;
        if (pulse_b) pcnt_b++;
        if (rel_b)   rcnt_b++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Edge index (0 = first posedge after the call) at which the selected output is seen high.
    task automatic wait_sig(input int which, input int maxn, output int edge_idx);
        logic v;
        edge_idx = -1;
        for (int n = 0; n < maxn; n++) begin
            @(posedge clk);
            #2;
            case (which)
                0:       v = pulse_a;
                1:       v = rel_a;
                2:       v = pulse_b;
                default: v = rel_b;
            endcase
            if (v) begin
                edge_idx = n;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int p0, r0;

        // Reset held with the button pressed.
        step(3);
        check("rst_level_a", int'(level_a), 0);
        check("rst_pulse_a", int'(pulse_a), 0);
        check("rst_release_a", int'(rel_a), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_sig(0, 20, e);
        check("post_reset_press_edge", e, 6);
        check("post_reset_pcnt", pcnt_a, 0);

        // Clean release.
        btn_a = 1'b1;
        wait_sig(1, 20, e);
        check("release_edge", e, 6);
        check("release_level", int'(level_a), 0);
        step(3);

        // Clean press held for 20 cycles.
        p0 = pcnt_a;
        btn_a = 1'b0;
        wait_sig(0, 20, e);
        check("press_edge", e, 6);
        check("press_level", int'(level_a), 1);
        step(20);
        check("press_single_pulse", pcnt_a - p0, 1);
        check("press_held_level", int'(level_a), 1);

        // Two-cycle release glitch.
        r0 = rcnt_a;
        btn_a = 1'b1;
        step(2);
        btn_a = 1'b0;
        step(10);
        check("glitch_no_release", rcnt_a - r0, 0);
        check("glitch_level", int'(level_a), 1);

        btn_a = 1'b1;
        wait_sig(1, 20, e);
        check("release2_edge", e, 6);
        check("release2_level", int'(level_a), 0);
        step(10);

        // Bounce: runs of 1, 2 and 3 cycles, then stable pressed.
        p0 = pcnt_a;
        for (int k = 1; k <= 3; k++) begin
            btn_a = 1'b0;
            step(k);
            btn_a = 1'b1;
            step(k);
        end
        check("bounce_no_pulse", pcnt_a - p0, 0);
        btn_a = 1'b0;
        wait_sig(0, 20, e);
        check("bounce_press_edge", e, 6);
        step(10);
        check("bounce_single_pulse", pcnt_a - p0, 1);

        // Reset two cycles into press qualification, button kept held.
        btn_a = 1'b1;
        step(15);
        p0 = pcnt_a;
        btn_a = 1'b0;
        step(4);
        rst_a = 1'b1;
        #1;
        check("midrst_level", int'(level_a), 0);
        check("midrst_pulse", int'(pulse_a), 0);
        step(2);
        rst_a = 1'b0;
        wait_sig(0, 20, e);
        check("midrst_press_edge", e, 6);
        step(30);
        check("midrst_single_pulse", pcnt_a - p0, 1);

        // Active-high input, single-cycle qualification.
        btn_b = 1'b1;
        wait_sig(2, 20, e);
        check("b_press_edge", e, 3);
        btn_b = 1'b0;
        step(8);
        p0 = pcnt_b;
        r0 = rcnt_b;
        for (int k = 0; k < 4; k++) begin
            btn_b = 1'b1;
            step(4);
            btn_b = 1'b0;
            step(4);
        end
        step(6);
        check("b_pulse_count", pcnt_b - p0, 4);
        check("b_release_count", rcnt_b - r0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the enable-gated D flip-flop registers.
- Takes a raw, asynchronous, bouncing push-button or switch input and synchronises it into the clk domain.
- Filters it with a stable-time counter FSM.
- Produces a clean level plus single-cycle press/release pulses; btn_pulse drives the en pin of the downstream flip-flop, so one physical press causes exactly one capture.

Parameters:
- STABLE_CYCLES, 1000000, consecutive clk cycles the synchronised input must hold a new value before it is accepted (20 ms at 50 MHz); legal range >= 1.
- SYNC_STAGES, 2, synchroniser flip-flop depth; legal range >= 2.
- ACTIVE_LOW, 1, 1 = btn_in reads 0 when pressed (board keys); 0 = btn_in reads 1 when pressed.
- CNT_WIDTH (localparam), $clog2(STABLE_CYCLES+1), counter width; not user-overridable.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button level.
- btn_level  output  1  debounced level, 1 = pressed, independent of ACTIVE_LOW.
- btn_pulse  output  1  one-cycle high on each accepted press.
- btn_release  output  1  one-cycle high on each accepted release.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values:
  - All outputs 0, counter 0, FSM in IDLE.
  - Synchroniser flops reset to the not-pressed raw level: 1 if ACTIVE_LOW, else 0.
- Synchroniser and normalisation:
  - SYNC_STAGES-deep shift register on btn_in, then inverted when ACTIVE_LOW.
  - Call the normalised output s; s = 1 means pressed.
- IDLE (btn_level = 0): s = 1 -> WAIT_PRESS, cnt <= 0. Otherwise stay.
- WAIT_PRESS (btn_level = 0):
  - s = 0 -> IDLE with no pulse; this is the bounce rejection path.
  - Else if cnt == STABLE_CYCLES-1 -> PRESSED, assert btn_pulse.
  - Else cnt <= cnt+1.
- PRESSED (btn_level = 1): s = 0 -> WAIT_RELEASE, cnt <= 0. Otherwise stay; no repeat pulses while held.
- WAIT_RELEASE (btn_level = 1):
  - s = 1 -> PRESSED with no pulse.
  - Else if cnt == STABLE_CYCLES-1 -> IDLE, assert btn_release.
  - Else cnt <= cnt+1.
- All outputs are registered, with no combinational path from btn_in.
- btn_pulse and btn_release are high for exactly one cycle, in the cycle after the transition edge.
- Latency:
  - Count edge 0 as the first posedge sampling a new stable btn_in.
  - The FSM enters PRESSED (or IDLE, for release) at edge SYNC_STAGES+STABLE_CYCLES.
  - btn_pulse / btn_level (or btn_release) change in the cycle following that edge.
- Counter:
  - Never exceeds STABLE_CYCLES-1.
  - Cleared on every WAIT state entry.
  - Cannot wrap.
- Boundary conditions:
  - STABLE_CYCLES = 1: acceptance one cycle after s changes.
  - btn_pulse and btn_release are never high in the same cycle.
  - A glitch shorter than STABLE_CYCLES at any point restarts qualification; it never produces a pulse.
- Reset mid-operation: immediate return to IDLE with outputs 0. No pulse is emitted on reset release, even if the button is held; a held button is re-qualified from IDLE.

Decomposition:
- Shared package pbl_pkg:
  - Debouncer state encoding: IDLE = 2'd0, WAIT_PRESS = 2'd1, PRESSED = 2'd2, WAIT_RELEASE = 2'd3.
  - CLK_FREQ_HZ = 50000000.
  - DEBOUNCE_MS = 20, from which STABLE_CYCLES defaults derive.
- Sub-module sync_ff:
  - Parameterised SYNC_STAGES-deep synchroniser with reset value parameter.
  - Reused for other asynchronous inputs (switches).

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1 unless stated):
1. Reset: assert rst for 3 cycles with btn_in = 0 (pressed) -> all outputs 0 during reset. After release, btn_pulse rises exactly 6 cycles later; no pulse is caused by reset itself.
2. Clean press: btn_in 1 -> 0, held 20 cycles -> btn_pulse high exactly one cycle, 6 edges after the first sampling edge. btn_level = 1 from the same cycle and stays 1; no further pulses.
3. Bounce: btn_in toggles 0/1 with runs of 1, 2 and 3 cycles, then stays 0 -> zero pulses during bouncing. One btn_pulse occurs 6 edges after the final stable edge.
4. Release: from PRESSED, btn_in -> 1 for 20 cycles -> btn_release one cycle after 6 edges, btn_level falls with it. A 2-cycle release glitch yields no btn_release and btn_level stays 1.
5. Reset mid-qualification: assert rst 2 cycles into WAIT_PRESS -> outputs 0. After rst drops with the button held, one btn_pulse occurs 6 cycles later; a counter overflow check passes.
6. ACTIVE_LOW=0, STABLE_CYCLES=1: btn_in 0 -> 1 -> btn_pulse 3 edges later. Four back-to-back presses of 4 cycles each with 4-cycle gaps -> exactly 4 pulses and 4 releases.
